sysid_ext: RTL and testbench
============================

Name: sysid_ext

Overview:
Parametrised system-identification slave for the Platform Designer (Qsys) system. It sits on the Avalon-MM interconnect next to the CPU and gives software a consistent view of the build:
- read-only ID and timestamp words
- a capability word
- a scratch register
- a 64-bit uptime counter with coherent high-word capture
- N build-info user words

Reads are pipelined with a configurable fixed latency and use readdatavalid. This block is the successor to the single-address combinational ID slave.

Parameters:
DATA_W, 32, data width; fixed at 32 (the capability encoding depends on it).
ADDR_W, 4, word address width; addresses 0..2^ADDR_W-1.
ID_VALUE, 32'h76C8C13A, system ID word.
TIMESTAMP, 32'h5CA35539, build timestamp (Unix seconds).
NUM_USER_WORDS, 2, number of user info words; range 0..(2^ADDR_W-7).
USER_WORDS, {NUM_USER_WORDS{32'h0}}, packed user words; word k is bits [32k+31:32k].
READ_LATENCY, 1, cycles from read accept to readdatavalid; range 1..3.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  ADDR_W  word address
read  in  1  read request; accepted every cycle it is high (no waitrequest)
write  in  1  write request; accepted every cycle it is high
writedata  in  32  write data
readdata  out  32  read data, valid when readdatavalid=1
readdatavalid  out  1  read response strobe

Behaviour:
Interface:
- clk is the single clock.
- reset_n is asynchronous active-low: assertion takes effect immediately, deassertion is synchronous to clk.

Address map:
- 0 ID_VALUE (RO)
- 1 TIMESTAMP (RO)
- 2 CAP (RO): [31:16]=16'h0002 version, [15:8]=READ_LATENCY, [7:0]=NUM_USER_WORDS
- 3 SCRATCH (RW), reset 32'h0
- 4 UPTIME_LO (RO); a read also latches counter[63:32] into HI_SHADOW in the same cycle
- 5 HI_SHADOW (RO), reset 0
- 6 CTRL/STATUS:
  - read returns {30'h0, 1'b0, bad_access}
  - write bit0=1 clears the uptime counter
  - write bit1=1 clears bad_access
- 7..7+NUM_USER_WORDS-1 USER_WORDS[k] (RO)
- All higher addresses are unmapped.

Uptime counter:
- 64-bit, reset 0, increments by 1 every clk and wraps from 2^64-1 to 0.
- A clear write makes the counter 0 on the next edge; it increments from there.
- A UPTIME_LO read returns the pre-increment value of that cycle; HI_SHADOW receives bits [63:32] of the same value.

Read pipeline:
- read data is selected and captured on the accept edge, then passes through a READ_LATENCY-deep valid/data pipeline.
- Back-to-back reads (one per cycle) are supported and return in order.
- readdatavalid=1 exactly READ_LATENCY cycles after each accepted read; readdata is 0 whenever readdatavalid=0.

Writes:
- Zero latency, no response.
- Writes to RO addresses are ignored.
- Writes to unmapped addresses are ignored and set bad_access.

Unmapped reads: return 32'h0 and set bad_access.

bad_access:
- sticky; reset 0.
- If a set and a clear occur in the same cycle, set wins.

Simultaneous read and write in one cycle:
- Both are performed.
- The read returns the pre-write value.
- A same-cycle UPTIME_LO read plus clear returns the old value; the counter becomes 0.

Reset mid-operation: all in-flight reads are discarded; readdatavalid=0, readdata=0, SCRATCH=0, counter=0, HI_SHADOW=0, bad_access=0.

Elaboration: out-of-range parameters produce an elaboration error ($error in a generate check).

Decomposition:
Package sysid_ext_pkg holds:
- address constants (ADDR_ID=0 .. ADDR_USER0=7)
- CAP_VERSION=16'h0002
- CTRL bit indices (CLR_UPTIME=0, CLR_ERR=1)
- a function that builds the CAP word

One sub-module, sysid_rd_pipe: a parametrised valid/data delay line (depth READ_LATENCY, async active-low reset) used for the read return path.

Test Plan:
- Reset, then read addresses 0, 1, 2 back-to-back with READ_LATENCY=2 -> three readdatavalid pulses starting 2 cycles after the first read, data 32'h76C8C13A, 32'h5CA35539, 32'h00020202.
- Write 32'hDEADBEEF to addr 3, then read addr 3 -> 32'hDEADBEEF; same-cycle read+write of 32'h1 to addr 3 -> returns 32'hDEADBEEF, and a later read returns 32'h1.
- Force the counter to 64'h0000_0000_FFFF_FFFF, read addr 4 then addr 5 -> 32'hFFFFFFFF then 32'h0 (coherent, not 1); a subsequent addr-4 read shows a rollover into the high word.
- Write 32'h1 to addr 6, read addr 4 three cycles later -> value 2 (counter 0 on the edge after the write, +1 per cycle).
- Read addr 15 with NUM_USER_WORDS=2 -> 32'h0 and addr 6 reads 32'h1; write 32'h2 to addr 6 -> addr 6 reads 32'h0.
- Issue three reads then assert reset_n=0 asynchronously mid-pipeline -> readdatavalid drops immediately, and no stale responses appear after release.

Source files
------------

// File: rtl/sysid_ext_pkg.sv
// Shared constants and helpers for the sysid_ext system-identification slave.
package sysid_ext_pkg;

  localparam logic [31:0] ADDR_ID        = 32'd0;
  localparam logic [31:0] ADDR_TIMESTAMP = 32'd1;
  localparam logic [31:0] ADDR_CAP       = 32'd2;
  localparam logic [31:0] ADDR_SCRATCH   = 32'd3;
  localparam logic [31:0] ADDR_UPTIME_LO = 32'd4;
  localparam logic [31:0] ADDR_HI_SHADOW = 32'd5;
  localparam logic [31:0] ADDR_CTRL      = 32'd6;
  localparam logic [31:0] ADDR_USER0     = 32'd7;

  localparam logic [15:0] CAP_VERSION = 16'h0002;

  localparam int CLR_UPTIME = 0;
  localparam int CLR_ERR    = 1;

  // Capability word: version in the top half, latency and user-word count below.
  function automatic logic [31:0] build_cap(input int read_latency, input int num_user_words);
    return {CAP_VERSION, 8'(read_latency), 8'(num_user_words)};
  endfunction

endpackage

// File: rtl/sysid_rd_pipe.sv
// Fixed-depth valid/data delay line for the read return path; data is zero when not valid.
module sysid_rd_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] valid_q;
  logic [W-1:0]     data_q [DEPTH];

  // Stage 0 captures the selected word on the accept edge; later stages just shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_valid ? in_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/sysid_ext.sv
// System-identification Avalon-MM slave: ID, timestamp, capabilities, scratch,
// 64-bit uptime with coherent high-word capture, and build-info user words.
module sysid_ext
  import sysid_ext_pkg::*;
#(
  parameter int          DATA_W         = 32,
  parameter int          ADDR_W         = 4,
  parameter logic [31:0] ID_VALUE       = 32'h76C8C13A,
  parameter logic [31:0] TIMESTAMP      = 32'h5CA35539,
  parameter int          NUM_USER_WORDS = 2,
  parameter logic [(NUM_USER_WORDS > 0 ? NUM_USER_WORDS : 1)*32-1:0] USER_WORDS = '0,
  parameter int          READ_LATENCY   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("sysid_ext: DATA_W must be 32");
  end
  if (NUM_USER_WORDS < 0 || NUM_USER_WORDS > (2**ADDR_W - 7)) begin : g_bad_num_user
    $error("sysid_ext: NUM_USER_WORDS out of range");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
    $error("sysid_ext: READ_LATENCY must be 1..3");
  end

  logic [63:0]       uptime;
  logic [DATA_W-1:0] scratch;
  logic [DATA_W-1:0] hi_shadow;
  logic              bad_access;

  logic [31:0]       addr_ext;
  logic [DATA_W-1:0] rd_word;
  logic              is_mapped;
  logic              wr_ctrl;
  logic              clr_uptime;
  logic              clr_err;
  logic              set_err;

  assign addr_ext   = 32'(address);
  assign wr_ctrl    = write && (addr_ext == ADDR_CTRL);
  assign clr_uptime = wr_ctrl && writedata[CLR_UPTIME];
  assign clr_err    = wr_ctrl && writedata[CLR_ERR];
  assign set_err    = (read || write) && !is_mapped;

  // Decode the shared address into the read word (pre-write state) and a mapped flag.
  always_comb begin
    rd_word   = '0;
    is_mapped = 1'b1;
    case (addr_ext)
      ADDR_ID:        rd_word = ID_VALUE;
      ADDR_TIMESTAMP: rd_word = TIMESTAMP;
      ADDR_CAP:       rd_word = build_cap(READ_LATENCY, NUM_USER_WORDS);
      ADDR_SCRATCH:   rd_word = scratch;
      ADDR_UPTIME_LO: rd_word = uptime[31:0];
      ADDR_HI_SHADOW: rd_word = hi_shadow;
      ADDR_CTRL:      rd_word = {30'h0, 1'b0, bad_access};
      default: begin
        is_mapped = 1'b0;
        for (int k = 0; k < NUM_USER_WORDS; k++) begin
          if (addr_ext == ADDR_USER0 + 32'(k)) begin
            rd_word   = USER_WORDS[k*32 +: 32];
            is_mapped = 1'b1;
          end
        end
      end
    endcase
  end

  // Free-running uptime counter; a clear write zeroes it on the following edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) uptime <= '0;
    else if (clr_uptime) uptime <= '0;
    else uptime <= uptime + 64'd1;
  end

  // Latch the high word alongside every UPTIME_LO read so the pair is coherent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hi_shadow <= '0;
    else if (read && (addr_ext == ADDR_UPTIME_LO)) hi_shadow <= uptime[63:32];
  end

  // Software scratch register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) scratch <= '0;
    else if (write && (addr_ext == ADDR_SCRATCH)) scratch <= writedata;
  end

  // Sticky unmapped-access flag; a new set takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bad_access <= 1'b0;
    else if (set_err) bad_access <= 1'b1;
    else if (clr_err) bad_access <= 1'b0;
  end

  sysid_rd_pipe #(
    .DEPTH (READ_LATENCY),
    .W     (DATA_W)
  ) u_rd_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (read),
    .in_data   (rd_word),
    .out_valid (readdatavalid),
    .out_data  (readdata)
  );

endmodule

// File: tb/tb_sysid_ext.sv
// Self-checking bench for sysid_ext: a register-level model predicts every read
// response, and directed sequences pin the model with literal expectations.
module tb_sysid_ext;

  localparam int          LAT   = 2;
  localparam int          NUSER = 2;
  localparam logic [31:0] ID    = 32'h76C8C13A;
  localparam logic [31:0] TS    = 32'h5CA35539;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  int errors = 0;
  int checks = 0;

  sysid_ext #(
    .DATA_W         (32),
    .ADDR_W         (4),
    .ID_VALUE       (ID),
    .TIMESTAMP      (TS),
    .NUM_USER_WORDS (NUSER),
    .USER_WORDS     (64'hCAFE0001_12345678),
    .READ_LATENCY   (LAT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  always #5 clk = ~clk;

  // Model state
  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        ent;
  int          edge_n = 0;
  logic [63:0] m_cnt = '0;
  logic [31:0] m_scratch = '0;
  logic [31:0] m_shadow = '0;
  logic        m_bad = 1'b0;
  logic        m_forced = 1'b0;
  logic [63:0] m_force_val = '0;
  logic [31:0] user_words [NUSER] = '{32'h12345678, 32'hCAFE0001};
  logic [63:0] up_now;
  logic [31:0] rv;
  int          a;
  logic        mapped;

  // Register-level model: evaluates each accepted cycle and schedules responses.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      m_cnt = '0;
      m_scratch = '0;
      m_shadow = '0;
      m_bad = 1'b0;
    end else begin
      edge_n++;
      up_now = m_forced ? m_force_val : m_cnt;
      a = int'(address);
      mapped = (a < 7 + NUSER);
      if (read) begin
        rv = '0;
        if (a == 0) rv = ID;
        else if (a == 1) rv = TS;
        else if (a == 2) rv = (32'h2 << 16) | (32'(LAT) << 8) | 32'(NUSER);
        else if (a == 3) rv = m_scratch;
        else if (a == 4) rv = up_now[31:0];
        else if (a == 5) rv = m_shadow;
        else if (a == 6) rv = {31'b0, m_bad};
        else if (a >= 7 && a < 7 + NUSER) rv = user_words[a - 7];
        ent.due = edge_n + LAT - 1;
        ent.data = rv;
        exp_q.push_back(ent);
        if (a == 4) m_shadow = up_now[63:32];
      end
      if ((read || write) && !mapped) m_bad = 1'b1;
      else if (write && a == 6 && writedata[1]) m_bad = 1'b0;
      if (write && a == 3) m_scratch = writedata;
      if (write && a == 6 && writedata[0]) m_cnt = '0;
      else m_cnt = m_cnt + 64'd1;
    end
  end

  logic        exp_v;
  logic [31:0] exp_d;

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    exp_v = 1'b0;
    exp_d = '0;
    if (reset_n === 1'b1 && exp_q.size() > 0 && exp_q[0].due == edge_n) begin
      exp_v = 1'b1;
      exp_d = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    checks++;
    if (readdatavalid !== exp_v || readdata !== exp_d) begin
      errors++;
      $display("[TB] FAIL model_cmp edge=%0d: got valid=%b data=%h, want valid=%b data=%h",
               edge_n, readdatavalid, readdata, exp_v, exp_d);
    end
  end

  task automatic apply_stimulus(input logic rd, input logic wr, input logic [3:0] addr,
                                input logic [31:0] wd);
    @(negedge clk);
    read = rd;
    write = wr;
    address = addr;
    writedata = wd;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, 4'd0, 32'h0);
  endtask

  task automatic check_output(input string name, input logic ev, input logic [31:0] ed);
    checks++;
    if (readdatavalid !== ev || readdata !== ed) begin
      errors++;
      $display("[TB] FAIL %s: got valid=%b data=%h, want valid=%b data=%h",
               name, readdatavalid, readdata, ev, ed);
    end
  endtask

  task automatic read_check(input string name, input logic [3:0] addr, input logic [31:0] ed);
    apply_stimulus(1'b1, 1'b0, addr, 32'h0);
    repeat (LAT) idle();
    check_output(name, 1'b1, ed);
  endtask

  // Directed sequences with hand-computed expectations.
  initial begin
    $display("[TB] start");
    #1 check_output("reset_outputs", 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle();
    idle();

    // back-to-back ID / TIMESTAMP / CAP
    apply_stimulus(1'b1, 1'b0, 4'd0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 4'd1, 32'h0);
    apply_stimulus(1'b1, 1'b0, 4'd2, 32'h0);
    check_output("b2b_id", 1'b1, 32'h76C8C13A);
    idle();
    check_output("b2b_ts", 1'b1, 32'h5CA35539);
    idle();
    check_output("b2b_cap", 1'b1, 32'h00020202);
    idle();
    check_output("b2b_gap", 1'b0, 32'h0);

    // scratch, including same-cycle read+write
    apply_stimulus(1'b0, 1'b1, 4'd3, 32'hDEADBEEF);
    read_check("scratch_wr", 4'd3, 32'hDEADBEEF);
    apply_stimulus(1'b1, 1'b1, 4'd3, 32'h1);
    repeat (LAT) idle();
    check_output("scratch_rw_old", 1'b1, 32'hDEADBEEF);
    read_check("scratch_rw_new", 4'd3, 32'h1);

    // writes to read-only words are ignored
    apply_stimulus(1'b0, 1'b1, 4'd0, 32'hFFFFFFFF);
    read_check("ro_id", 4'd0, 32'h76C8C13A);
    apply_stimulus(1'b0, 1'b1, 4'd2, 32'h0);
    read_check("ro_cap", 4'd2, 32'h00020202);
    read_check("bad_clean", 4'd6, 32'h0);

    // coherent high-word capture around a 32-bit rollover
    idle();
    force dut.uptime = 64'h0000_0000_FFFF_FFFF;
    m_force_val = 64'h0000_0000_FFFF_FFFF;
    m_forced = 1'b1;
    read_check("uptime_lo_pre", 4'd4, 32'hFFFFFFFF);
    read_check("hi_shadow_pre", 4'd5, 32'h0);
    force dut.uptime = 64'h0000_0001_0000_0000;
    m_force_val = 64'h0000_0001_0000_0000;
    read_check("uptime_lo_roll", 4'd4, 32'h0);
    read_check("hi_shadow_roll", 4'd5, 32'h1);
    release dut.uptime;
    m_forced = 1'b0;

    // counter clear: 0 after the write edge, then +1 per cycle
    apply_stimulus(1'b0, 1'b1, 4'd6, 32'h1);
    idle();
    idle();
    read_check("uptime_clear", 4'd4, 32'h2);
    read_check("hi_after_clear", 4'd5, 32'h0);

    // bad_access: unmapped read, sticky, cleared, unmapped write
    read_check("unmapped_rd", 4'd15, 32'h0);
    read_check("bad_set_rd", 4'd6, 32'h1);
    apply_stimulus(1'b0, 1'b1, 4'd6, 32'h2);
    read_check("bad_cleared", 4'd6, 32'h0);
    apply_stimulus(1'b0, 1'b1, 4'd10, 32'h5);
    read_check("bad_set_wr", 4'd6, 32'h1);
    apply_stimulus(1'b0, 1'b1, 4'd6, 32'h2);
    read_check("bad_cleared2", 4'd6, 32'h0);

    // user words and the first unmapped address above them
    read_check("user0", 4'd7, 32'h12345678);
    read_check("user1", 4'd8, 32'hCAFE0001);
    read_check("user_past_end", 4'd9, 32'h0);
    read_check("bad_user_end", 4'd6, 32'h1);

    // reset in the middle of three pipelined reads
    apply_stimulus(1'b1, 1'b0, 4'd0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 4'd1, 32'h0);
    apply_stimulus(1'b1, 1'b0, 4'd2, 32'h0);
    check_output("pre_reset_valid", 1'b1, 32'h76C8C13A);
    #2;
    reset_n = 1'b0;
    read = 1'b0;
    #1 check_output("reset_drop", 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      check_output("no_stale", 1'b0, 32'h0);
    end
    read_check("scratch_after_rst", 4'd3, 32'h0);
    read_check("bad_after_rst", 4'd6, 32'h0);
    read_check("hi_after_rst", 4'd5, 32'h0);
    repeat (3) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
